// File: rtl/edge_handshake_rx.sv
// Receive side of a four-phase req/ack event link: synchronizes req, returns ack,
// pulses edge_o once per event and queues events in a saturating pending counter.
module edge_handshake_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic                 req_async_i,
  output logic                 ack_o,
  output logic                 edge_o,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [CNT_WIDTH-1:0] pend_cnt_o,
  output logic                 overflow_o
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   accept_c;
  logic                   pop_c;
  logic                   ovf_set_c;
  logic [CNT_WIDTH-1:0]   cnt_next_c;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Counter update: a simultaneous accept and pop cancel; a full counter drops the event.
  always_comb begin
    accept_c   = (state == IDLE) && req_s && en_i;
    pop_c      = evt_valid_o && evt_ready_i;
    ovf_set_c  = 1'b0;
    cnt_next_c = pend_cnt_o;
    if (accept_c && !pop_c) begin
      if (pend_cnt_o == CNT_MAX) begin
        ovf_set_c = 1'b1;
      end else begin
        cnt_next_c = pend_cnt_o + CNT_WIDTH'(1);
      end
    end else if (pop_c && !accept_c) begin
      cnt_next_c = pend_cnt_o - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q      <= '0;
      state       <= IDLE;
      ack_o       <= 1'b0;
      edge_o      <= 1'b0;
      evt_valid_o <= 1'b0;
      pend_cnt_o  <= '0;
      overflow_o  <= 1'b0;
    end else begin
      // req_async_i goes straight into the first flop, nothing ahead of it
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_async_i};
      edge_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_s) begin
            state  <= ACK;
            ack_o  <= 1'b1;
            edge_o <= en_i;
          end
        end
        ACK: begin
          if (!req_s) begin
            state <= IDLE;
            ack_o <= 1'b0;
          end
        end
      endcase
      pend_cnt_o  <= cnt_next_c;
      evt_valid_o <= (cnt_next_c != '0);
      overflow_o  <= overflow_o | ovf_set_c;
    end
  end

endmodule

// File: tb/tb_edge_handshake_rx.sv
// Directed bench for edge_handshake_rx (SYNC_STAGES=2, CNT_WIDTH=2 so saturation is reachable).
module tb_edge_handshake_rx;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_WIDTH   = 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 en = 1'b1;
  logic                 req = 1'b0;
  logic                 ack;
  logic                 edge_p;
  logic                 evt_valid;
  logic                 evt_ready = 1'b0;
  logic [CNT_WIDTH-1:0] pend_cnt;
  logic                 overflow;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  edge_handshake_rx #(.SYNC_STAGES(SYNC_STAGES), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .en_i        (en),
    .req_async_i (req),
    .ack_o       (ack),
    .edge_o      (edge_p),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .pend_cnt_o  (pend_cnt),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  // Count edge_o pulses once per cycle, away from the active edge
  always @(negedge clk) if (edge_p === 1'b1) edge_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic level);
    int n = 0;
    while (ack !== level && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ack !== level) begin
      errors++;
      $display("FAIL wait_ack: ack=%b required %b within 20 cycles", ack, level);
    end
  endtask

  task automatic handshake();
    req = 1'b1;
    wait_ack(1'b1);
    req = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 1'b0; en = 1'b1; evt_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({ack, edge_p, evt_valid, overflow, pend_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: ack=%b edge=%b valid=%b ovf=%b cnt=%0d required all 0",
               ack, edge_p, evt_valid, overflow, pend_cnt);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    req = 1'b1;
    tick(); tick();
    checks++;
    if (ack !== 1'b0 || edge_p !== 1'b0) begin
      errors++;
      $display("FAIL early_ack: ack=%b edge=%b after N+1 required 0 0", ack, edge_p);
    end
    tick();
    checks++;
    if (ack !== 1'b1 || edge_p !== 1'b1 || pend_cnt !== 2'd1 || evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL rise_latency: ack=%b edge=%b cnt=%0d valid=%b required 1 1 1 1",
               ack, edge_p, pend_cnt, evt_valid);
    end
    tick();
    checks++;
    if (edge_p !== 1'b0 || ack !== 1'b1) begin
      errors++;
      $display("FAIL edge_width: edge=%b ack=%b required 0 1", edge_p, ack);
    end
  endtask

  task automatic test_fall_and_hold();
    int e0;
    e0 = edge_cnt;
    req = 1'b0;
    tick(); tick();
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL early_fall: ack=%b after N+1 required 1", ack);
    end
    tick();
    checks++;
    if (ack !== 1'b0 || edge_cnt != e0) begin
      errors++;
      $display("FAIL fall_latency: ack=%b edges=%0d required 0 %0d", ack, edge_cnt, e0);
    end
    req = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (edge_cnt != e0 + 1 || pend_cnt !== 2'd2) begin
      errors++;
      $display("FAIL long_hold: edges=%0d cnt=%0d required %0d 2", edge_cnt, pend_cnt, e0 + 1);
    end
    req = 1'b0;
    wait_ack(1'b0);
    evt_ready = 1'b1;
    tick(); tick();
    evt_ready = 1'b0;
    checks++;
    if (pend_cnt !== 2'd0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: cnt=%0d valid=%b required 0 0", pend_cnt, evt_valid);
    end
  endtask

  task automatic test_queue_pop();
    logic [CNT_WIDTH-1:0] exp_cnt;
    for (int i = 0; i < 3; i++) handshake();
    checks++;
    if (pend_cnt !== 2'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL queue3: cnt=%0d ovf=%b required 3 0", pend_cnt, overflow);
    end
    evt_ready = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      tick();
      exp_cnt = CNT_WIDTH'(i);
      checks++;
      if (pend_cnt !== exp_cnt || evt_valid !== (i != 0)) begin
        errors++;
        $display("FAIL pop_seq: cnt=%0d valid=%b required %0d %b", pend_cnt, evt_valid, i, i != 0);
      end
    end
    tick();
    checks++;
    if (pend_cnt !== 2'd0) begin
      errors++;
      $display("FAIL underflow: cnt=%0d required 0", pend_cnt);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_accept_pop();
    handshake(); handshake();
    req = 1'b1;
    tick(); tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (edge_p !== 1'b1 || pend_cnt !== 2'd2) begin
      errors++;
      $display("FAIL accept_pop: edge=%b cnt=%0d required 1 2", edge_p, pend_cnt);
    end
    req = 1'b0;
    wait_ack(1'b0);
    evt_ready = 1'b1;
    tick(); tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int e0;
    e0 = edge_cnt;
    for (int i = 0; i < 3; i++) handshake();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: ovf=%b required 0", overflow);
    end
    handshake();
    checks++;
    if (pend_cnt !== 2'd3 || overflow !== 1'b1 || edge_cnt != e0 + 4) begin
      errors++;
      $display("FAIL saturate: cnt=%0d ovf=%b edges=%0d required 3 1 %0d",
               pend_cnt, overflow, edge_cnt, e0 + 4);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    evt_ready = 1'b0;
    checks++;
    if (pend_cnt !== 2'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: cnt=%0d ovf=%b required 0 1", pend_cnt, overflow);
    end
  endtask

  task automatic test_disable_and_reset();
    int e0;
    e0 = edge_cnt;
    en = 1'b0;
    handshake();
    en = 1'b1;
    checks++;
    if (edge_cnt != e0 || pend_cnt !== 2'd0) begin
      errors++;
      $display("FAIL disabled: edges=%0d cnt=%0d required %0d 0", edge_cnt, pend_cnt, e0);
    end
    req = 1'b1;
    wait_ack(1'b1);
    rstn = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0 || pend_cnt !== 2'd0 || overflow !== 1'b0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ack=%b cnt=%0d ovf=%b valid=%b required 0 0 0 0",
               ack, pend_cnt, overflow, evt_valid);
    end
    rstn = 1'b1;
    tick(); tick();
    checks++;
    if (ack !== 1'b0 || edge_p !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early: ack=%b edge=%b required 0 0", ack, edge_p);
    end
    tick();
    checks++;
    if (ack !== 1'b1 || edge_p !== 1'b1 || pend_cnt !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_event: ack=%b edge=%b cnt=%0d required 1 1 1", ack, edge_p, pend_cnt);
    end
    req = 1'b0;
    wait_ack(1'b0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fall_and_hold();
    test_queue_pop();
    test_accept_pop();
    test_overflow();
    test_disable_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
